// File: rtl/pipelined_barrel_shifter.sv
// Purpose : parametrised barrel shifter, one register stage per shift level, with a user tag.
// Latency : LOG2W cycles from acceptance to out_valid; one operation per cycle when unstalled.
// Backpr. : bubble-collapsing valid/ready; each stage stalls only if it and all later stages are full.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_data, in_shamt, in_dir, in_op, in_tag operation fields
//   out_valid/out_ready output handshake; out_data, out_tag result, out_zero = (out_data == 0)
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 16,
  parameter  int TAG_W = 4,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic             in_dir,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam logic [1:0] OP_ARI = 2'b01;
  localparam logic [1:0] OP_ROT = 2'b10;

  // Stage registers; index LOG2W-1 is the output stage.
  logic [LOG2W-1:0] r_vld;
  logic [WIDTH-1:0] r_data  [LOG2W];
  logic [LOG2W-1:0] r_shamt [LOG2W];
  logic [LOG2W-1:0] r_dir;
  logic [1:0]       r_op    [LOG2W];
  logic [LOG2W-1:0] r_sign;
  logic [TAG_W-1:0] r_tag   [LOG2W];

  // Values presented to each stage by its upstream neighbour (the input port for stage 0).
  logic [LOG2W-1:0] w_up_vld;
  logic [WIDTH-1:0] w_up_data  [LOG2W];
  logic [LOG2W-1:0] w_up_shamt [LOG2W];
  logic [LOG2W-1:0] w_up_dir;
  logic [1:0]       w_up_op    [LOG2W];
  logic [LOG2W-1:0] w_up_sign;
  logic [TAG_W-1:0] w_up_tag   [LOG2W];
  logic [WIDTH-1:0] w_nxt_data [LOG2W];
  logic [LOG2W-1:0] w_rdy;

  // One shift level. sgn is the operand MSB captured at acceptance, so the arithmetic
  // fill never depends on an intermediate MSB. op=11 falls through to the logical paths.
  function automatic logic [WIDTH-1:0] f_shift(
    input logic [WIDTH-1:0] d,
    input int               s,
    input logic             dir,
    input logic [1:0]       op,
    input logic             sgn
  );
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> s);
    if (op == OP_ROT) begin
      res = dir ? ((d >> s) | (d << (WIDTH - s))) : ((d << s) | (d >> (WIDTH - s)));
    end else if (!dir) begin
      res = d << s;
    end else if ((op == OP_ARI) && sgn) begin
      res = (d >> s) | fill;
    end else begin
      res = d >> s;
    end
    return res;
  endfunction

  // ready[k] = !valid[k] || ready[k+1], unrolled as a running OR from the output side
  // so no combinational array feeds back on itself.
  always_comb begin
    logic v_acc;
    v_acc = out_ready;
    w_rdy = '0;
    for (int k = LOG2W - 1; k >= 0; k--) begin
      v_acc    = v_acc | ~r_vld[k];
      w_rdy[k] = v_acc;
    end
  end

  always_comb begin
    w_up_vld  = '0;
    w_up_dir  = '0;
    w_up_sign = '0;
    w_up_vld[0]   = in_valid;
    w_up_data[0]  = in_data;
    w_up_shamt[0] = in_shamt;
    w_up_dir[0]   = in_dir;
    w_up_op[0]    = in_op;
    w_up_sign[0]  = in_data[WIDTH-1];
    w_up_tag[0]   = in_tag;
    for (int k = 1; k < LOG2W; k++) begin
      w_up_vld[k]   = r_vld[k-1];
      w_up_data[k]  = r_data[k-1];
      w_up_shamt[k] = r_shamt[k-1];
      w_up_dir[k]   = r_dir[k-1];
      w_up_op[k]    = r_op[k-1];
      w_up_sign[k]  = r_sign[k-1];
      w_up_tag[k]   = r_tag[k-1];
    end
    // Stage k handles distance 2^(LOG2W-1-k), largest first.
    for (int k = 0; k < LOG2W; k++) begin
      w_nxt_data[k] = w_up_shamt[k][LOG2W-1-k]
                    ? f_shift(w_up_data[k], 1 << (LOG2W - 1 - k), w_up_dir[k], w_up_op[k], w_up_sign[k])
                    : w_up_data[k];
    end
  end

  // Payload registers load whenever the stage is ready, valid or not; only the valid bit
  // gives them meaning. A held output stage is never ready, so out_* stays frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_dir  <= '0;
      r_sign <= '0;
      for (int k = 0; k < LOG2W; k++) begin
        r_data[k]  <= '0;
        r_shamt[k] <= '0;
        r_op[k]    <= '0;
        r_tag[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < LOG2W; k++) begin
        if (w_rdy[k]) begin
          r_vld[k]   <= w_up_vld[k];
          r_data[k]  <= w_nxt_data[k];
          r_shamt[k] <= w_up_shamt[k];
          r_dir[k]   <= w_up_dir[k];
          r_op[k]    <= w_up_op[k];
          r_sign[k]  <= w_up_sign[k];
          r_tag[k]   <= w_up_tag[k];
        end
      end
    end
  end

  assign in_ready  = w_rdy[0] & ~rst;
  assign out_valid = r_vld[LOG2W-1];
  assign out_data  = r_data[LOG2W-1];
  assign out_tag   = r_tag[LOG2W-1];
  assign out_zero  = (r_data[LOG2W-1] == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (WIDTH=16, TAG_W=4): mode/edge vector table,
// then backpressure, bubble-collapse, concurrent in/out and mid-operation reset sequences.
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic        in_dir;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic        out_zero;

  pipelined_barrel_shifter #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
    .in_dir(in_dir), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] data;
    logic [3:0]  shamt;
    logic        dir;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] data;
  } res_t;

  vec_t vecs[$];
  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cur;
  int   n_acc;
  int   n_out;
  logic last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One clock with scoreboard bookkeeping; inputs are already driven by the caller.
  task automatic cycle();
    logic acc, xf;
    #1;
    acc = in_valid && in_ready;
    xf  = out_valid && out_ready;
    if (xf) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {28'd0, out_tag}, 32'hFFFF_FFFF);
      end else begin
        chk("stream_tag", {28'd0, out_tag}, {28'd0, exp_q[0].tag});
        chk("stream_data", {16'd0, out_data}, {16'd0, exp_q[0].data});
        void'(exp_q.pop_front());
      end
      n_out++;
    end
    if (acc) begin
      exp_q.push_back('{tag: 4'(cur), data: 16'(cur * 16'h1010)});
      n_acc++;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  // Stream items: data = t*0x0101, logical left 4, so the result is t*0x1010.
  task automatic stream_cycle(input logic vld);
    in_valid = vld;
    in_data  = 16'(cur * 16'h0101);
    in_tag   = 4'(cur);
    in_shamt = 4'd4;
    in_dir   = 1'b0;
    in_op    = 2'b00;
    cycle();
    if (last_acc) cur++;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int lat;
    string nm;
    nm = $sformatf("vec%0d", idx);
    in_valid = 1'b1;
    in_data  = v.data;
    in_shamt = v.shamt;
    in_dir   = v.dir;
    in_op    = v.op;
    in_tag   = v.tag;
    #1;
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 99;
    for (int c = 1; c <= 10 && !out_valid; c++) begin
      @(posedge clk);
      #1;
      lat = c + 1;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_data"}, {16'd0, out_data}, {16'd0, v.exp});
    chk({nm, "_tag"}, {28'd0, out_tag}, {28'd0, v.tag});
    chk({nm, "_zero"}, {31'd0, out_zero}, {31'd0, (v.exp == 16'd0)});
  endtask

  initial begin
    //           data      sh    dir   op     tag   expected
    vecs.push_back('{16'hD011, 4'd2,  1'b1, 2'b01, 4'h1, 16'hF404}); // arith right 2
    vecs.push_back('{16'hD011, 4'd4,  1'b1, 2'b00, 4'h2, 16'h0D01}); // logical right 4
    vecs.push_back('{16'hD011, 4'd8,  1'b0, 2'b00, 4'h3, 16'h1100}); // logical left 8
    vecs.push_back('{16'hD011, 4'd4,  1'b1, 2'b10, 4'h4, 16'h1D01}); // rotate right 4
    vecs.push_back('{16'hD011, 4'd1,  1'b0, 2'b10, 4'h5, 16'hA023}); // rotate left 1
    vecs.push_back('{16'hD011, 4'd2,  1'b1, 2'b11, 4'h6, 16'h3404}); // reserved = logical
    vecs.push_back('{16'hD011, 4'd0,  1'b1, 2'b00, 4'h7, 16'hD011}); // shamt 0, all modes
    vecs.push_back('{16'hD011, 4'd0,  1'b1, 2'b01, 4'h8, 16'hD011});
    vecs.push_back('{16'hD011, 4'd0,  1'b0, 2'b10, 4'h9, 16'hD011});
    vecs.push_back('{16'hD011, 4'd0,  1'b0, 2'b11, 4'hA, 16'hD011});
    vecs.push_back('{16'h8000, 4'd15, 1'b1, 2'b01, 4'hB, 16'hFFFF}); // arith right 15
    vecs.push_back('{16'h8000, 4'd15, 1'b1, 2'b00, 4'hC, 16'h0001}); // logical right 15
    vecs.push_back('{16'h0001, 4'd1,  1'b1, 2'b00, 4'hD, 16'h0000}); // shifts to zero
    vecs.push_back('{16'hD011, 4'd2,  1'b0, 2'b01, 4'hE, 16'h4044}); // arith left = logical
    vecs.push_back('{16'hD011, 4'd15, 1'b0, 2'b10, 4'hF, 16'hE808}); // rotate left 15
    vecs.push_back('{16'h4000, 4'd14, 1'b1, 2'b01, 4'h0, 16'h0001}); // arith right, positive

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_dir = 1'b0;
    in_op = 2'b00; in_tag = '0; out_ready = 1'b1;
    n_acc = 0; n_out = 0; cur = 1; last_acc = 1'b0;

    // Reset state.
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Mode and edge-amount vectors.
    foreach (vecs[i]) apply_vec(vecs[i], i);
    @(posedge clk);
    #1;

    // Backpressure: 6 inputs, out_ready low for 6 cycles.
    cur = 1; n_acc = 0; n_out = 0; exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stream_cycle(1'b1);
      if (i >= 3) begin
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_tag", {28'd0, out_tag}, 32'd1);
        chk("bp_hold_data", {16'd0, out_data}, 32'h1010);
      end
    end
    chk("bp_accepts", n_acc, 4);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (cur <= 6 || exp_q.size() > 0); i++) stream_cycle(cur <= 6);
    chk("bp_outputs", n_out, 6);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Bubble collapse: valid on alternate cycles with out_ready low.
    cur = 1; n_acc = 0; n_out = 0; exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) stream_cycle(i % 2 == 0);
    chk("bub_accepts", n_acc, 4);
    chk("bub_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) stream_cycle(1'b0);
    chk("bub_outputs", n_out, 4);

    // Concurrent in/out with a full pipeline.
    cur = 1; n_acc = 0; n_out = 0; exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) stream_cycle(1'b1);
    chk("conc_fill", n_acc, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      #1;
      chk("conc_in_ready", {31'd0, in_ready}, 32'd1);
      chk("conc_out_valid", {31'd0, out_valid}, 32'd1);
      #1;
      stream_cycle(1'b1);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) stream_cycle(1'b0);
    chk("conc_accepts", n_acc, 14);
    chk("conc_outputs", n_out, 14);

    // Reset mid-operation: 3 in flight, oldest already at the output and held.
    cur = 1; n_acc = 0; n_out = 0; exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) stream_cycle(1'b1);
    stream_cycle(1'b0);
    chk("rm_out_valid_before", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rm_out_zero", {31'd0, out_zero}, 32'd1);
    chk("rm_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rm_in_ready", {31'd0, in_ready}, 32'd0);
    #1;
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    n_out = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) n_out++;
      @(posedge clk);
      #1;
    end
    chk("rm_no_stale", n_out, 0);
    apply_vec('{16'hD011, 4'd4, 1'b1, 2'b10, 4'h9, 16'h1D01}, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
